// File: rtl/clock_pkg.sv
// Shared definitions for the BCD clock: set-mode encoding and field bit map.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_e;

    localparam int FLD_SEC = 0;
    localparam int FLD_MIN = 1;
    localparam int FLD_HR  = 2;
    localparam int NUM_FLD = 3;

    typedef logic [NUM_FLD-1:0] field_t;

    // One-hot field indication for a mode; all zeros while running.
    function automatic field_t field_of(state_e s);
        field_t f;
        f = '0;
        case (s)
            ST_SET_HR:  f[FLD_HR]  = 1'b1;
            ST_SET_MIN: f[FLD_MIN] = 1'b1;
            ST_SET_SEC: f[FLD_SEC] = 1'b1;
            default:    f = '0;
        endcase
        return f;
    endfunction

    // Mode sequence stepped by each set press.
    function automatic state_e next_mode(state_e s);
        case (s)
            ST_RUN:     return ST_SET_HR;
            ST_SET_HR:  return ST_SET_MIN;
            ST_SET_MIN: return ST_SET_SEC;
            default:    return ST_RUN;
        endcase
    endfunction

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability debouncer and
// single-cycle press/release events derived from the debounced level.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int            CW       = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_prev_q;
    logic [CW-1:0] stable_cnt_q;

    // Synchronise the raw pin and accept a new level only once it has differed for DB_CYCLES cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_q         <= 1'b0;
            db_prev_q    <= 1'b0;
            stable_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so each flop samples its pre-edge source; blocking here would collapse the synchroniser into one stage.
            sync1_q   <= i_btn;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            if (sync2_q == db_q) begin
                stable_cnt_q <= '0;
            end else if (stable_cnt_q >= CNT_LAST) begin
                db_q         <= sync2_q;
                stable_cnt_q <= '0;
            end else begin
                stable_cnt_q <= stable_cnt_q + CW'(1);
            end
        end
    end

    assign o_level   = db_q;
    assign o_press   = db_q & ~db_prev_q;
    assign o_release = ~db_q & db_prev_q;

endmodule

// File: rtl/set_ctrl.sv
// Time-setting controller: mode FSM, auto-repeat increment pulses and idle
// timeout, driving the seconds count enable and the per-field set pulses.
module set_ctrl
    import clock_pkg::*;
#(
    parameter int DB_CYCLES  = 4,
    parameter int REPEAT_DLY = 20,
    parameter int REPEAT_PER = 5,
    parameter int TIMEOUT_S  = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_set,
    input  logic               i_up,
    input  logic               i_sec_tick,
    output logic               o_cnt_en,
    output logic [NUM_FLD-1:0] o_set_en,
    output logic [NUM_FLD-1:0] o_field
);

    localparam int RP_MAX = max2(REPEAT_DLY, REPEAT_PER);
    localparam int RW     = $clog2(RP_MAX) + 1;
    localparam int TW     = $clog2(TIMEOUT_S) + 1;

    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);
    localparam logic [RW-1:0] RP_SAT   = RW'(RP_MAX);
    localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_S > 0) ? TIMEOUT_S - 1 : 0);
    localparam logic [TW-1:0] TO_SAT   = TW'(TIMEOUT_S);
    localparam bit            TO_ON    = (TIMEOUT_S != 0);

    logic set_press, set_release, set_level;
    logic up_press, up_release, up_level;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_btn (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_btn     (i_set),
        .o_level   (set_level),
        .o_press   (set_press),
        .o_release (set_release)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_up_btn (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_btn     (i_up),
        .o_level   (up_level),
        .o_press   (up_press),
        .o_release (up_release)
    );

    state_e        state_q;
    logic          cnt_en_q;
    field_t        set_en_q;
    field_t        field_q;
    logic          rep_armed_q;
    logic          rep_first_q;
    logic [RW-1:0] rep_cnt_q;
    logic [TW-1:0] to_cnt_q;

    logic          in_set, any_event, timeout_hit, mode_adv;
    logic          up_fire, rep_fire, pulse;
    logic [RW-1:0] rep_target;
    state_e        state_d;

    // Decode this cycle's mode change and whether an increment pulse is due.
    always_comb begin
        // NOTE: every signal is assigned on every pass through this block, so no latch can be inferred.
        in_set      = (state_q != ST_RUN);
        any_event   = set_press | set_release | up_press | up_release;
        timeout_hit = TO_ON && in_set && i_sec_tick && !any_event && (to_cnt_q >= TO_LAST);
        mode_adv    = set_press | timeout_hit;
        state_d     = timeout_hit ? ST_RUN : next_mode(state_q);
        rep_target  = rep_first_q ? DLY_LAST : PER_LAST;
        up_fire     = in_set && up_press;
        rep_fire    = in_set && up_level && rep_armed_q && !(|set_en_q) && (rep_cnt_q >= rep_target);
        pulse       = !mode_adv && (up_fire || rep_fire);
    end

    // Mode FSM with registered outputs, repeat timer and idle-seconds timeout.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_RUN;
            cnt_en_q    <= 1'b0;
            set_en_q    <= '0;
            field_q     <= '0;
            rep_armed_q <= 1'b0;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= '0;
            to_cnt_q    <= '0;
        end else begin
            cnt_en_q <= (state_q == ST_RUN) && i_sec_tick;
            set_en_q <= pulse ? field_of(state_q) : '0;

            if (mode_adv) begin
                state_q     <= state_d;
                field_q     <= field_of(state_d);
                rep_armed_q <= 1'b0;
                rep_first_q <= 1'b0;
                rep_cnt_q   <= '0;
                to_cnt_q    <= '0;
            end else begin
                if (!in_set || !up_level) begin
                    rep_armed_q <= 1'b0;
                    rep_first_q <= 1'b0;
                    rep_cnt_q   <= '0;
                end else if (up_fire) begin
                    rep_armed_q <= 1'b1;
                    rep_first_q <= 1'b1;
                    rep_cnt_q   <= '0;
                end else if (rep_fire) begin
                    rep_first_q <= 1'b0;
                    rep_cnt_q   <= '0;
                end else if (rep_armed_q && (rep_cnt_q < RP_SAT)) begin
                    rep_cnt_q <= rep_cnt_q + RW'(1);
                end

                if (!in_set || any_event) begin
                    to_cnt_q <= '0;
                end else if (i_sec_tick && (to_cnt_q < TO_SAT)) begin
                    to_cnt_q <= to_cnt_q + TW'(1);
                end
            end
        end
    end

    assign o_cnt_en = cnt_en_q;
    assign o_set_en = set_en_q;
    assign o_field  = field_q;

endmodule
